// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that shares the single-port data memory between the core's
// execute stage and an auxiliary requester, sequencing one fixed-latency access at a time.
module data_memory_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int LATENCY      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    core_read,
  input  logic                    core_write,
  input  logic [ADDRESS_SIZE-1:0] core_address,
  input  logic [DATA_SIZE-1:0]    core_wdata,
  output logic                    core_stall,
  output logic [DATA_SIZE-1:0]    core_rdata,
  input  logic                    aux_valid,
  input  logic                    aux_write,
  input  logic [ADDRESS_SIZE-1:0] aux_address,
  input  logic [DATA_SIZE-1:0]    aux_wdata,
  output logic                    aux_ready,
  output logic [DATA_SIZE-1:0]    aux_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  input  logic [DATA_SIZE-1:0]    mem_rdata,
  output logic                    busy
);

  localparam int COUNT_SIZE = $clog2(LATENCY + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  logic [0:0]              state_reg;
  logic                    owner_reg;
  logic                    last_owner_reg;
  logic                    op_write_reg;
  logic                    core_done_reg;
  logic                    aux_ready_reg;
  logic [COUNT_SIZE-1:0]   count_reg;
  logic [DATA_SIZE-1:0]    rdata_reg;
  logic                    mem_en_reg;
  logic                    mem_we_reg;
  logic [ADDRESS_SIZE-1:0] mem_address_reg;
  logic [DATA_SIZE-1:0]    mem_wdata_reg;

  logic core_request;
  logic core_eligible;
  logic aux_eligible;
  logic grant_aux;

  // A requester whose done flag is high is still presenting the request that
  // just completed, so it must not be granted again in that cycle.
  assign core_request  = core_read | core_write;
  assign core_eligible = core_request && !core_done_reg;
  assign aux_eligible  = aux_valid && !aux_ready_reg;

  always_comb begin
    grant_aux = 1'b0;
    if (aux_eligible && (!core_eligible || last_owner_reg == OWNER_CORE)) begin
      grant_aux = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      owner_reg       <= OWNER_CORE;
      last_owner_reg  <= OWNER_AUX;
      op_write_reg    <= 1'b0;
      core_done_reg   <= 1'b0;
      aux_ready_reg   <= 1'b0;
      count_reg       <= '0;
      rdata_reg       <= '0;
      mem_en_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      core_done_reg <= 1'b0;
      aux_ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (core_eligible || aux_eligible) begin
            state_reg      <= BUSY;
            owner_reg      <= grant_aux;
            last_owner_reg <= grant_aux;
            mem_en_reg     <= 1'b1;
            count_reg      <= COUNT_SIZE'(LATENCY);
            if (grant_aux) begin
              op_write_reg    <= aux_write;
              mem_we_reg      <= aux_write;
              mem_address_reg <= aux_address;
              mem_wdata_reg   <= aux_wdata;
            end else begin
              // A simultaneous read and write from the core is treated as a write.
              op_write_reg    <= core_write;
              mem_we_reg      <= core_write;
              mem_address_reg <= core_address;
              mem_wdata_reg   <= core_wdata;
            end
          end
        end
        default: begin
          count_reg <= count_reg - COUNT_SIZE'(1);
          if (count_reg == COUNT_SIZE'(1)) begin
            if (!op_write_reg) begin
              rdata_reg <= mem_rdata;
            end
            if (owner_reg == OWNER_AUX) begin
              aux_ready_reg <= 1'b1;
            end else begin
              core_done_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign core_stall  = core_request && !core_done_reg;
  assign core_rdata  = rdata_reg;
  assign aux_rdata   = rdata_reg;
  assign aux_ready   = aux_ready_reg;
  assign mem_en      = mem_en_reg;
  assign mem_we      = mem_we_reg;
  assign mem_address = mem_address_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign busy        = (state_reg == BUSY);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-timeline model and a reference memory.
module tb_data_memory_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          core_read = 1'b0, core_write = 1'b0;
  logic [AW-1:0] core_address = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          aux_valid = 1'b0, aux_write = 1'b0;
  logic [AW-1:0] aux_address = '0;
  logic [DW-1:0] aux_wdata = '0;
  logic          aux_ready;
  logic [DW-1:0] aux_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clock = ~clock;

  data_memory_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_address(core_address),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
    .aux_valid(aux_valid), .aux_write(aux_write), .aux_address(aux_address),
    .aux_wdata(aux_wdata), .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] mem_default(int a);
    return 32'hA5C3_0000 + DW'(a);
  endfunction

  // Memory device: data is only valid LAT cycles after the strobe, garbage otherwise.
  logic [DW-1:0] mem_model [0:255];
  bit            written [0:255];
  int            age = 100;
  int            write_count = 0;

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      mem_model[mem_address[7:0]] <= mem_wdata;
      written[mem_address[7:0]]   <= 1'b1;
      write_count <= write_count + 1;
    end
    age <= mem_en ? 1 : ((age < 100) ? age + 1 : age);
  end

  assign mem_rdata = (age == LAT - 1) ?
                     (written[mem_address[7:0]] ? mem_model[mem_address[7:0]] : mem_default(int'(mem_address[7:0])))
                     : 32'hBAD0_BAD0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          core_q[$];
  req_t          aux_q[$];
  req_t          core_cur, aux_cur, g;
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] exp_rdata, pending_rdata;
  int            cyc = 0;
  int            grant_cyc, core_done_cyc, aux_done_cyc, rd_done_cyc;
  bit            core_active, aux_active, core_pend, aux_pend, last_aux, g_aux;
  int            en_log[$];
  int            rdy_log[$];
  logic [AW-1:0] addr_log[$];
  int            tests = 0;
  int            fails = 0;

  task automatic check_value(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_core(logic rd, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.data = d;
    core_q.push_back(r);
  endtask

  task automatic push_aux(logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    req_t r;
    r.rd = !wr; r.wr = wr; r.addr = a; r.data = d;
    aux_q.push_back(r);
  endtask

  task automatic model_reset();
    core_q.delete(); aux_q.delete();
    core_active = 0; aux_active = 0; core_pend = 0; aux_pend = 0;
    last_aux = 1;
    grant_cyc = -100; core_done_cyc = -100; aux_done_cyc = -100; rd_done_cyc = -100;
    exp_rdata = '0;
    core_read = 0; core_write = 0; aux_valid = 0;
  endtask

  // Requesters hold a request from issue until the cycle after its done cycle.
  task automatic drive();
    if (core_active && core_done_cyc == cyc - 1) core_active = 0;
    if (aux_active && aux_done_cyc == cyc - 1) aux_active = 0;
    if (!core_active && core_q.size() > 0) begin
      core_cur = core_q.pop_front(); core_active = 1; core_pend = 1;
    end
    if (!aux_active && aux_q.size() > 0) begin
      aux_cur = aux_q.pop_front(); aux_active = 1; aux_pend = 1;
    end
    core_read    = core_active & core_cur.rd;
    core_write   = core_active & core_cur.wr;
    core_address = core_cur.addr;
    core_wdata   = core_cur.data;
    aux_valid    = aux_active;
    aux_write    = aux_cur.wr;
    aux_address  = aux_cur.addr;
    aux_wdata    = aux_cur.data;
  endtask

  // Timeline model: a grant in cycle G owns the memory for G+1..G+LAT, done in G+LAT+1.
  task automatic model_check();
    bit exp_en, in_busy;
    exp_en  = (grant_cyc == cyc - 1);
    in_busy = (cyc > grant_cyc) && (cyc <= grant_cyc + LAT);
    check_value("mem_en", mem_en, exp_en);
    check_value("mem_we", mem_we, exp_en && g.wr);
    check_value("busy", busy, in_busy);
    if (in_busy) begin
      check_value("mem_address", mem_address, g.addr);
      check_value("mem_wdata", mem_wdata, g.data);
    end
    if (mem_en) begin
      en_log.push_back(cyc);
      addr_log.push_back(mem_address);
    end
    if (aux_ready) rdy_log.push_back(cyc);
    if (cyc == rd_done_cyc) exp_rdata = pending_rdata;
    check_value("aux_ready", aux_ready, cyc == aux_done_cyc);
    check_value("core_stall", core_stall, (core_read | core_write) && (cyc != core_done_cyc));
    check_value("core_rdata", core_rdata, exp_rdata);
    check_value("aux_rdata", aux_rdata, exp_rdata);
    if (cyc > grant_cyc + LAT && (core_pend || aux_pend)) begin
      g_aux = aux_pend && (!core_pend || !last_aux);
      g = g_aux ? aux_cur : core_cur;
      last_aux = g_aux;
      grant_cyc = cyc;
      if (g_aux) begin aux_pend = 0; aux_done_cyc = cyc + LAT + 1; end
      else begin core_pend = 0; core_done_cyc = cyc + LAT + 1; end
      if (g.wr) ref_mem[g.addr[7:0]] = g.data;
      else begin pending_rdata = ref_mem[g.addr[7:0]]; rd_done_cyc = cyc + LAT + 1; end
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    drive();
    @(negedge clock);
    model_check();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  // Reset lands mid-cycle, away from any clock edge, to exercise the asynchronous path.
  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check_value("rst_mem_en", mem_en, 1'b0);
    check_value("rst_mem_we", mem_we, 1'b0);
    check_value("rst_mem_address", mem_address, '0);
    check_value("rst_mem_wdata", mem_wdata, '0);
    check_value("rst_rdata", core_rdata, '0);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_aux_ready", aux_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic clear_logs();
    en_log.delete(); rdy_log.delete(); addr_log.delete();
  endtask

  initial begin
    int s, wc0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_default(i);
    core_cur = '{rd: 1'b0, wr: 1'b0, addr: '0, data: '0};
    aux_cur  = core_cur;
    g        = core_cur;
    apply_reset();

    // Core load after an aux preload of the word it will read.
    push_aux(1'b1, 32'h010, 32'hDEAD_BEEF);
    run(6);
    clear_logs();
    s = cyc + 1;
    push_core(1'b1, 1'b0, 32'h010, 32'h0);
    run(4);
    check_value("t1_stall_released", core_stall, 1'b0);
    check_value("t1_rdata", core_rdata, 32'hDEAD_BEEF);
    run(3);
    check_value("t1_en_count", en_log.size(), 1);
    if (en_log.size() == 1) check_value("t1_en_cycle", en_log[0] - s, 1);

    // Core store.
    wc0 = write_count;
    push_core(1'b0, 1'b1, 32'h020, 32'h1234_5678);
    run(6);
    check_value("t2_write_count", write_count - wc0, 1);
    check_value("t2_mem_content", mem_model[8'h20], 32'h1234_5678);

    // Simultaneous core and aux read right after reset: core first.
    apply_reset();
    clear_logs();
    s = cyc + 1;
    push_core(1'b1, 1'b0, 32'h040, 32'h0);
    push_aux(1'b0, 32'h041, 32'h0);
    run(8);
    check_value("t3_en_count", en_log.size(), 2);
    check_value("t3_ready_count", rdy_log.size(), 1);
    if (en_log.size() == 2) begin
      check_value("t3_core_en_cycle", en_log[0] - s, 1);
      check_value("t3_aux_en_cycle", en_log[1] - s, 4);
    end
    if (rdy_log.size() == 1) check_value("t3_aux_ready_cycle", rdy_log[0] - s, 6);

    // Both held continuously: owners must alternate.
    clear_logs();
    push_core(1'b1, 1'b0, 32'h100, 32'h0);
    push_core(1'b1, 1'b1, 32'h101, 32'h5555_AAAA);
    push_aux(1'b1, 32'h200, 32'h0BAD_CAFE);
    push_aux(1'b0, 32'h201, 32'h0);
    run(16);
    check_value("t4_en_count", en_log.size(), 4);
    if (addr_log.size() == 4) begin
      check_value("t4_owner0", addr_log[0], 32'h100);
      check_value("t4_owner1", addr_log[1], 32'h200);
      check_value("t4_owner2", addr_log[2], 32'h101);
      check_value("t4_owner3", addr_log[3], 32'h201);
    end

    // Aux back-to-back with aux_valid kept high.
    run(3);
    clear_logs();
    s = cyc + 1;
    push_aux(1'b0, 32'h001, 32'h0);
    push_aux(1'b0, 32'h002, 32'h0);
    run(9);
    check_value("t6_en_count", en_log.size(), 2);
    check_value("t6_ready_count", rdy_log.size(), 2);
    if (en_log.size() == 2) begin
      check_value("t6_en0", en_log[0] - s, 1);
      check_value("t6_en1", en_log[1] - s, 5);
    end
    if (rdy_log.size() == 2) begin
      check_value("t6_ready0", rdy_log[0] - s, 3);
      check_value("t6_ready1", rdy_log[1] - s, 7);
    end

    // Reset in the second BUSY cycle drops the access with no done pulse.
    clear_logs();
    push_aux(1'b0, 32'h033, 32'h0);
    run(3);
    apply_reset();
    run(8);
    check_value("t5_no_ready", rdy_log.size(), 0);
    check_value("t5_no_reissue", en_log.size(), 1);
    push_aux(1'b0, 32'h033, 32'h0);
    run(6);
    check_value("t5_rerequest_ready", rdy_log.size(), 1);

    // Random traffic from both requesters.
    for (int i = 0; i < 1500; i++) begin
      if (core_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        push_core(op != 1, op != 0, AW'($urandom_range(0, 255)), $urandom);
      end
      if (aux_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        push_aux($urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), $urandom);
      end
      step();
    end
    run(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
